// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side write signals shared by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int N_REQ      = 4
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic                        fifo_wr_full;
    logic                        fifo_wr_en;
    logic [DATA_WIDTH-1:0]       fifo_din;

    modport master (
        output req_valid, req_data, req_last, fifo_wr_full,
        input  req_ready, fifo_wr_en, fifo_din
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_wr_full,
        output req_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter feeding the async_fifo write port.
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 64,
    parameter  int N_REQ      = 4,
    parameter  int MAX_BURST  = 4,
    localparam int GW         = $clog2(N_REQ),
    localparam int CW         = $clog2(MAX_BURST + 1)
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    fifo_wr_arbiter_if.slave  bus,
    input  logic [N_REQ-1:0]  cfg_en,
    output logic              grant_valid,
    output logic [GW-1:0]     grant_id,
    output logic [31:0]       beat_total
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         idx;
    logic [CW-1:0]         beat_cnt;
    logic [N_REQ-1:0]      cand;
    logic                  found;
    logic                  xfer;
    logic                  end_burst;
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    assign cand = bus.req_valid & cfg_en;

    // Scan starts just after the last owner, so it gets lowest priority.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GW'((int'(last_grant) + k) % N_REQ);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Reset gates the beat so nothing is written in the aborting cycle.
    assign xfer = (state == BURST) && bus.req_valid[grant_id]
               && !bus.fifo_wr_full && !wr_rst;

    assign end_burst = bus.req_last[grant_id]
                    || (beat_cnt == CW'(MAX_BURST - 1));

    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_din   = data_arr[grant_id];

    always_comb begin
        bus.req_ready           = '0;
        bus.req_ready[grant_id] = xfer;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_grant  <= GW'(N_REQ - 1);
            beat_cnt    <= '0;
            beat_total  <= '0;
            grant_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_id    <= pick;
                        beat_cnt    <= '0;
                        state       <= BURST;
                        grant_valid <= 1'b1;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_total <= beat_total + 32'd1;
                        if (end_burst) begin
                            last_grant  <= grant_id;
                            beat_cnt    <= '0;
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter against a grant/packet level model.
module tb_fifo_wr_arbiter;
    localparam int DW = 64;
    localparam int N  = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cfg_en;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic [31:0]   beat_total;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N)) bus ();

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .wr_clk     (clk),
        .wr_rst     (rst),
        .bus        (bus),
        .cfg_en     (cfg_en),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .beat_total (beat_total)
    );

    always #5 clk = ~clk;

    // stimulus state
    logic [N-1:0] want = '1;
    logic [N-1:0] cfg  = '1;
    logic         full = 1'b0;
    logic         rst_d = 1'b1;
    beat_t        pq [N][$];

    // reference model state
    bit           m_known = 0;
    bit           m_busy  = 0;
    int           m_owner = 0;
    int           m_last  = N - 1;
    int           m_taken = 0;
    logic [31:0]  m_total = '0;
    bit           exp_xfer = 0;
    logic [N-1:0] exp_ready = '0;
    logic [DW-1:0] exp_q [$];

    int           grant_log [$];
    logic [31:0]  total_log [$];
    bit           prev_gv = 0;

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_pkt(int i, int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = {$urandom, $urandom};
            b.l = (j == len - 1);
            pq[i].push_back(b);
        end
    endtask

    task automatic clear_pq();
        for (int i = 0; i < N; i++) pq[i].delete();
    endtask

    // One clock: drive at negedge, predict, then advance the model at posedge.
    task automatic cycle();
        logic [N-1:0] v;
        beat_t        h;
        bit           nb;
        int           no, nl, ntk, sel;
        logic [31:0]  ntot;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            v[i] = want[i] && (pq[i].size() > 0);
            h = '0;
            if (pq[i].size() > 0) h = pq[i][0];
            bus.req_data[i*DW +: DW] = h.d;
            bus.req_last[i]          = h.l;
        end
        bus.req_valid    = v;
        bus.fifo_wr_full = full;
        cfg_en           = cfg;
        rst              = rst_d;
        #1;
        exp_xfer  = 0;
        exp_ready = '0;
        nb = m_busy; no = m_owner; nl = m_last; ntk = m_taken; ntot = m_total;
        if (rst_d) begin
            nb = 0; no = 0; nl = N - 1; ntk = 0; ntot = '0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                sel = (m_last + k) % N;
                if (!nb && v[sel] && cfg[sel]) begin
                    nb = 1; no = sel; ntk = 0;
                end
            end
        end else if (v[m_owner] && !full) begin
            exp_xfer = 1;
            exp_ready[m_owner] = 1'b1;
            exp_q.push_back(pq[m_owner][0].d);
            ntot = ntot + 32'd1;
            ntk++;
            if (pq[m_owner][0].l || ntk == MB) begin
                nb = 0; nl = m_owner; ntk = 0;
            end
        end
        @(posedge clk);
        if (exp_xfer) void'(pq[m_owner].pop_front());
        m_busy = nb; m_owner = no; m_last = nl; m_taken = ntk; m_total = ntot;
        if (rst_d) m_known = 1;
    endtask

    task automatic run(int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset(int n);
        rst_d = 1'b1;
        run(n);
        rst_d = 1'b0;
        grant_log.delete();
        total_log.delete();
    endtask

    task automatic chk_log(string name, int exp []);
        chk({name, "_count"}, 64'(grant_log.size() >= exp.size()), 64'd1);
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk(name, 64'(grant_log[i]), 64'(exp[i]));
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            chk("wr_en", 64'(bus.fifo_wr_en), 64'(exp_xfer));
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            if (bus.fifo_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_asrt++;
                    n_fail++;
                    $display("FAIL din: unexpected write of %0h, none expected",
                             bus.fifo_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("din", bus.fifo_din, e);
                end
            end else if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (m_known) begin
                chk("grant_valid", 64'(grant_valid), 64'(m_busy));
                chk("grant_id", 64'(grant_id), 64'(m_owner));
                chk("beat_total", 64'(beat_total), 64'(m_total));
                if (grant_valid && !prev_gv) begin
                    grant_log.push_back(int'(grant_id));
                    total_log.push_back(beat_total);
                end
                prev_gv = grant_valid;
            end
        end
    end

    initial begin
        beat_t b;
        int    fcnt;
        bit    hit;

        // reset with every requester valid
        for (int i = 0; i < N; i++) push_pkt(i, 2);
        want = '1; cfg = '1; full = 0;
        do_reset(3);

        // single 3-beat packet from requester 1
        clear_pq();
        want = 4'b0010;
        b.d = 64'hAAAA_0000_0000_000A; b.l = 0; pq[1].push_back(b);
        b.d = 64'hBBBB_0000_0000_000B; b.l = 0; pq[1].push_back(b);
        b.d = 64'hCCCC_0000_0000_000C; b.l = 1; pq[1].push_back(b);
        run(6);
        #1;
        chk("t2_total", 64'(beat_total), 64'd3);
        chk("t2_state", 64'(grant_valid), 64'd0);
        chk_log("t2_order", '{1});

        // all requesters streaming, forced rotation
        do_reset(1);
        clear_pq();
        for (int i = 0; i < N; i++) push_pkt(i, 30);
        want = '1;
        run(25);
        chk_log("t3_order", '{0, 1, 2, 3, 0});
        if (total_log.size() >= 5) chk("t3_total", 64'(total_log[4]), 64'd16);
        else chk("t3_total_seen", 64'(total_log.size()), 64'd5);

        // backpressure mid-burst
        do_reset(1);
        clear_pq();
        push_pkt(2, 4);
        want = 4'b0100;
        fcnt = 0;
        for (int c = 0; c < 40 && !(m_total == 4 && !m_busy); c++) begin
            full = (m_total == 2 && fcnt < 5);
            if (full) fcnt++;
            cycle();
        end
        full = 0;
        #1;
        chk("t4_total", 64'(beat_total), 64'd4);

        // enable mask, then drop requester 0 during its burst
        do_reset(1);
        clear_pq();
        for (int i = 0; i < N; i++) push_pkt(i, 30);
        want = '1;
        cfg = 4'b1011;
        for (int c = 0; c < 40 && grant_log.size() < 4; c++) cycle();
        cfg = 4'b1010;
        for (int c = 0; c < 20 && grant_log.size() < 5; c++) cycle();
        chk_log("t5_order", '{0, 1, 3, 0, 1});
        if (total_log.size() >= 5) chk("t5_total", 64'(total_log[4]), 64'd16);
        else chk("t5_total_seen", 64'(total_log.size()), 64'd5);
        cfg = '1;

        // reset during requester 3's second beat
        do_reset(1);
        clear_pq();
        for (int i = 0; i < N; i++) push_pkt(i, 30);
        want = '1;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            cycle();
            hit = m_busy && m_owner == 3 && m_taken == 1;
        end
        chk("t6_reached", 64'(hit), 64'd1);
        do_reset(1);
        #1;
        chk("t6_total", 64'(beat_total), 64'd0);
        chk("t6_idle", 64'(grant_valid), 64'd0);
        run(3);
        chk_log("t6_order", '{0});

        // randomized traffic
        do_reset(1);
        clear_pq();
        for (int c = 0; c < 800; c++) begin
            want  = N'($urandom);
            full  = ($urandom_range(0, 3) == 0);
            rst_d = ($urandom_range(0, 149) == 0);
            if (c % 50 == 0) cfg = N'($urandom);
            for (int i = 0; i < N; i++)
                if (pq[i].size() == 0) push_pkt(i, $urandom_range(1, 6));
            cycle();
        end
        rst_d = 0;
        full  = 0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule
